amiga_slot_arb: RTL and testbench

- Colour-clock DMA slot arbiter for the chip bus.
- Consumes the clock-enable outputs of the clock generator (clk7_en, cck) and divides each scan line into colour-clock slots.
- Assigns each slot to exactly one owner: refresh, disk, audio, sprite, bitplane, copper, blitter or CPU.
- Sits between the clock generator and the chip-RAM address multiplexer; the grant is held stable for the whole slot.

---
 rtl/amiga_slot_pkg.sv | 60 ++++++
 rtl/amiga_slot_map.sv | 26 ++
 rtl/amiga_slot_arb.sv | 119 +++++++++++
 tb/tb_amiga_slot_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/amiga_slot_pkg.sv
// Shared types and slot-map constants for the colour-clock DMA slot arbiter.
package amiga_slot_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      REF  = 4'd1,
      DSK  = 4'd2,
      AUD  = 4'd3,
      SPR  = 4'd4,
      BPL  = 4'd5,
      COP  = 4'd6,
      BLT  = 4'd7,
      CPU  = 4'd8
   } owner_e;

   typedef enum logic [2:0] {
      SLOT_FREE,
      SLOT_REF,
      SLOT_DSK,
      SLOT_AUD,
      SLOT_SPR
   } slot_class_e;

   localparam logic [7:0] REF_FIRST = 8'd1;
   localparam logic [7:0] REF_LAST  = 8'd7;
   localparam logic [7:0] DSK_FIRST = 8'd9;
   localparam logic [7:0] DSK_LAST  = 8'd13;
   localparam logic [7:0] AUD_FIRST = 8'd15;
   localparam logic [7:0] AUD_LAST  = 8'd21;
   localparam logic [7:0] SPR_FIRST = 8'd23;
   localparam logic [7:0] SPR_LAST  = 8'd53;

   localparam int GNT_IDLE = 0;
   localparam int GNT_REF  = 1;
   localparam int GNT_DSK  = 2;
   localparam int GNT_AUD  = 3;
   localparam int GNT_SPR  = 4;
   localparam int GNT_BPL  = 5;
   localparam int GNT_COP  = 6;
   localparam int GNT_BLT  = 7;
   localparam int GNT_CPU  = 8;

   function automatic logic [8:0] owner_to_gnt(input owner_e o);
      logic [8:0] g;
      g = '0;
      case (o)
         REF:     g[GNT_REF] = 1'b1;
         DSK:     g[GNT_DSK] = 1'b1;
         AUD:     g[GNT_AUD] = 1'b1;
         SPR:     g[GNT_SPR] = 1'b1;
         BPL:     g[GNT_BPL] = 1'b1;
         COP:     g[GNT_COP] = 1'b1;
         BLT:     g[GNT_BLT] = 1'b1;
         CPU:     g[GNT_CPU] = 1'b1;
         default: g[GNT_IDLE] = 1'b1;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/amiga_slot_map.sv
// Combinational map from the upcoming slot index to its fixed-slot class and audio channel.
module amiga_slot_map
   import amiga_slot_pkg::*;
(
   input  logic [7:0]  hpos_next,
   output slot_class_e slot_class,
   output logic [1:0]  aud_ch
);

   // Audio slots 15,17,19,21 carry channel (hpos[2:1] + 1) mod 4.
   always_comb begin
      slot_class = SLOT_FREE;
      aud_ch     = hpos_next[2:1] + 2'd1;
      if (hpos_next[0]) begin
         if (hpos_next >= REF_FIRST && hpos_next <= REF_LAST)
            slot_class = SLOT_REF;
         else if (hpos_next >= DSK_FIRST && hpos_next <= DSK_LAST)
            slot_class = SLOT_DSK;
         else if (hpos_next >= AUD_FIRST && hpos_next <= AUD_LAST)
            slot_class = SLOT_AUD;
         else if (hpos_next >= SPR_FIRST && hpos_next <= SPR_LAST)
            slot_class = SLOT_SPR;
      end
   end

endmodule

// File: rtl/amiga_slot_arb.sv
// Colour-clock DMA slot arbiter: one owner per colour-clock slot, held for the whole slot.
// Optional macro SLOT_ARB_BLIT_NICE_EN forces a CPU slot after NICE_LIMIT blitter wins.
module amiga_slot_arb
   import amiga_slot_pkg::*;
#(
   parameter int HPOS_MAX = 226
`ifdef SLOT_ARB_BLIT_NICE_EN
   , parameter int NICE_LIMIT = 3
`endif
)(
   input  logic       clk_28,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic       cck,
   input  logic       line_start,
   input  logic       dsk_en,
   input  logic       spr_en,
   input  logic [3:0] aud_en,
   input  logic       dsk_req,
   input  logic [3:0] aud_req,
   input  logic       spr_req,
   input  logic       bpl_req,
   input  logic       cop_req,
   input  logic       blt_req,
   input  logic       cpu_req,
   output logic       slot_strobe,
   output logic [7:0] hpos,
   output logic [3:0] owner,
   output logic [8:0] gnt
);

   logic        tick;
   logic        line_pend;
   logic [7:0]  hpos_next;
   logic [1:0]  aud_ch;
   logic        blt_yield;
   slot_class_e slot_class;
   owner_e      owner_q;
   owner_e      owner_next;

   assign tick = clk7_en & cck;

   amiga_slot_map u_map (
      .hpos_next  (hpos_next),
      .slot_class (slot_class),
      .aud_ch     (aud_ch)
   );

   always_comb begin
      if (line_start || line_pend || hpos == HPOS_MAX[7:0])
         hpos_next = 8'd0;
      else
         hpos_next = hpos + 8'd1;
   end

`ifdef SLOT_ARB_BLIT_NICE_EN
   logic [1:0] nice_cnt;

   assign blt_yield = cpu_req && (nice_cnt == NICE_LIMIT[1:0]);

   // Counts back-to-back blitter wins while the CPU waits; saturates at the limit.
   always_ff @(posedge clk_28) begin
      if (reset)
         nice_cnt <= 2'd0;
      else if (tick) begin
         if (!cpu_req || owner_next == CPU)
            nice_cnt <= 2'd0;
         else if (owner_next == BLT && nice_cnt != NICE_LIMIT[1:0])
            nice_cnt <= nice_cnt + 2'd1;
      end
   end
`else
   assign blt_yield = 1'b0;
`endif

   // Fixed slots win when their DMA is ready; anything else falls to the free chain.
   always_comb begin
      owner_next = IDLE;
      if (bpl_req)
         owner_next = BPL;
      else if (cop_req && !hpos_next[0])
         owner_next = COP;
      else if (blt_req && !blt_yield)
         owner_next = BLT;
      else if (cpu_req)
         owner_next = CPU;

      case (slot_class)
         SLOT_REF: owner_next = REF;
         SLOT_DSK: if (dsk_en && dsk_req) owner_next = DSK;
         SLOT_AUD: if (aud_en[aud_ch] && aud_req[aud_ch]) owner_next = AUD;
         SLOT_SPR: if (spr_en && spr_req && !bpl_req) owner_next = SPR;
         default:  ;
      endcase
   end

   // A line_start between ticks is remembered until the next tick consumes it.
   always_ff @(posedge clk_28) begin
      if (reset) begin
         hpos        <= 8'd0;
         owner_q     <= IDLE;
         slot_strobe <= 1'b0;
         line_pend   <= 1'b0;
      end else begin
         slot_strobe <= tick;
         if (line_start)
            line_pend <= 1'b1;
         if (tick) begin
            hpos      <= hpos_next;
            owner_q   <= owner_next;
            line_pend <= 1'b0;
         end
      end
   end

   assign owner = owner_q;
   assign gnt   = owner_to_gnt(owner_q);

endmodule

// File: tb/tb_amiga_slot_arb.sv
// Self-checking bench for amiga_slot_arb: vector table, corner sequences and a random run
// compared against a rule-level reference model.
module tb_amiga_slot_arb;
   import amiga_slot_pkg::*;

   localparam int HMAX     = 226;
   localparam int NICE_LIM = 3;

   typedef struct {
      bit       dsk_en, spr_en;
      bit [3:0] aud_en, aud_req;
      bit       dsk_req, spr_req, bpl_req, cop_req, blt_req, cpu_req;
      bit       line_mid, line_tick;
   } stim_t;

   typedef struct {
      stim_t  s;
      owner_e exp;
   } vec_t;

   logic       clk_28 = 1'b0;
   logic       reset = 1'b1;
   logic       clk7_en = 1'b0, cck = 1'b0, line_start = 1'b0;
   logic       dsk_en = 1'b0, spr_en = 1'b0, dsk_req = 1'b0;
   logic [3:0] aud_en = 4'd0, aud_req = 4'd0;
   logic       spr_req = 1'b0, bpl_req = 1'b0, cop_req = 1'b0, blt_req = 1'b0, cpu_req = 1'b0;
   logic       slot_strobe;
   logic [7:0] hpos;
   logic [3:0] owner;
   logic [8:0] gnt;

   int     n_cmp = 0, n_fail = 0;
   int     m_hpos = 0, m_nice = 0, cpu_wins = 0;
   owner_e last_owner = IDLE;
   vec_t   vecs[$];

   amiga_slot_arb dut (
      .clk_28(clk_28), .reset(reset), .clk7_en(clk7_en), .cck(cck), .line_start(line_start),
      .dsk_en(dsk_en), .spr_en(spr_en), .aud_en(aud_en), .dsk_req(dsk_req), .aud_req(aud_req),
      .spr_req(spr_req), .bpl_req(bpl_req), .cop_req(cop_req), .blt_req(blt_req),
      .cpu_req(cpu_req), .slot_strobe(slot_strobe), .hpos(hpos), .owner(owner), .gnt(gnt)
   );

   always #5 clk_28 = ~clk_28;

   function automatic stim_t mk(bit [3:0] ae, bit [3:0] ar, bit de, bit dr, bit se, bit sr,
                                bit b, bit c, bit t, bit u);
      stim_t s;
      s.aud_en = ae;  s.aud_req = ar;  s.dsk_en = de;  s.dsk_req = dr;
      s.spr_en = se;  s.spr_req = sr;  s.bpl_req = b;  s.cop_req = c;
      s.blt_req = t;  s.cpu_req = u;   s.line_mid = 1'b0; s.line_tick = 1'b0;
      return s;
   endfunction

   function automatic vec_t mk_vec(owner_e e, bit [3:0] ae, bit [3:0] ar, bit de, bit dr,
                                   bit se, bit sr, bit b, bit c, bit t, bit u);
      vec_t v;
      v.s   = mk(ae, ar, de, dr, se, sr, b, c, t, u);
      v.exp = e;
      return v;
   endfunction

   function automatic stim_t rnd_stim();
      stim_t s;
      s = mk(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             1'($urandom), 1'($urandom));
      s.line_mid  = ($urandom_range(0, 79) == 0);
      s.line_tick = ($urandom_range(0, 79) == 0);
      return s;
   endfunction

   // Reference owner for slot h, derived directly from the slot-allocation rules.
   function automatic owner_e model_owner(int h, stim_t s, int nice);
      bit odd = (h % 2 == 1);
      bit force_cpu;
      if (odd && h >= 1 && h <= 7) return REF;
      if (odd && h >= 9 && h <= 13 && s.dsk_en && s.dsk_req) return DSK;
      for (int n = 0; n < 4; n++)
         if (h == 15 + 2 * n && s.aud_en[n] && s.aud_req[n]) return AUD;
      if (odd && h >= 23 && h <= 53 && s.spr_en && s.spr_req && !s.bpl_req) return SPR;
      if (s.bpl_req) return BPL;
      if (s.cop_req && !odd) return COP;
`ifdef SLOT_ARB_BLIT_NICE_EN
      force_cpu = s.cpu_req && nice >= NICE_LIM;
`else
      force_cpu = (nice < 0);
`endif
      if (s.blt_req && !force_cpu) return BLT;
      if (s.cpu_req) return CPU;
      return IDLE;
   endfunction

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s (model hpos %0d): got %0d, expected %0d", name, m_hpos, act, exp);
      end
   endtask

   task automatic drive_reqs(stim_t s);
      dsk_en = s.dsk_en;   spr_en = s.spr_en;   aud_en = s.aud_en;   aud_req = s.aud_req;
      dsk_req = s.dsk_req; spr_req = s.spr_req; bpl_req = s.bpl_req; cop_req = s.cop_req;
      blt_req = s.blt_req; cpu_req = s.cpu_req;
   endtask

   // One colour clock: noise on the requests except in the tick cycle, then check the new slot.
   task automatic apply_stimulus(stim_t s, bit use_tbl, owner_e tbl_exp);
      int     exp_h;
      owner_e exp_o;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_28);
         if (i == 4) begin
            check_output("mid_slot_strobe", slot_strobe, 0);
            check_output("mid_slot_hold", owner, last_owner);
         end
         clk7_en    = (i % 4 == 3);
         cck        = (i >= 4);
         line_start = (i == 2 && s.line_mid) || (i == 7 && s.line_tick);
         if (i == 7) drive_reqs(s);
         else        drive_reqs(rnd_stim());
      end
      exp_h = (s.line_mid || s.line_tick || m_hpos == HMAX) ? 0 : m_hpos + 1;
      exp_o = use_tbl ? tbl_exp : model_owner(exp_h, s, m_nice);
      @(posedge clk_28);
      #1;
      line_start = 1'b0;
      m_hpos = exp_h;
      check_output("strobe", slot_strobe, 1);
      check_output("hpos", hpos, exp_h);
      check_output("owner", owner, exp_o);
      check_output("gnt", gnt, 9'b1 << int'(exp_o));
      if (!s.cpu_req || exp_o == CPU) m_nice = 0;
      else if (exp_o == BLT && m_nice < NICE_LIM) m_nice++;
      if (exp_o == CPU) cpu_wins++;
      last_owner = exp_o;
   endtask

   initial begin
      stim_t s;

      vecs.push_back(mk_vec(REF,  4'hF, 4'hF, 1, 1, 1, 1, 1, 1, 1, 1));
      vecs.push_back(mk_vec(BPL,  4'hF, 4'hF, 1, 1, 1, 1, 1, 1, 1, 1));
      vecs.push_back(mk_vec(REF,  4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk_vec(COP,  4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk_vec(REF,  4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(BLT,  4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk_vec(REF,  4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(IDLE, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(DSK,  4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(IDLE, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(CPU,  4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk_vec(COP,  4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk_vec(DSK,  4'h0, 4'h0, 1, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk_vec(IDLE, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(AUD,  4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(IDLE, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(CPU,  4'h2, 4'h1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk_vec(COP,  4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk_vec(AUD,  4'h4, 4'h4, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(BPL,  4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk_vec(AUD,  4'h8, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(IDLE, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(BPL,  4'h0, 4'h0, 0, 0, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk_vec(IDLE, 4'h0, 4'h0, 0, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk_vec(SPR,  4'h0, 4'h0, 0, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk_vec(BPL,  4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk_vec(BLT,  4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 1, 0));

      // Reset state, then hpos counting 1,2,3 with nothing requested.
      repeat (3) @(negedge clk_28);
      check_output("reset_gnt", gnt, 9'b000000001);
      check_output("reset_owner", owner, 0);
      check_output("reset_hpos", hpos, 0);
      check_output("reset_strobe", slot_strobe, 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, IDLE);

      // Vector table from slot 0 onwards.
      s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s.line_tick = 1'b1;
      apply_stimulus(s, 0, IDLE);
      foreach (vecs[k]) apply_stimulus(vecs[k].s, 1, vecs[k].exp);

      // line_start during slot 100.
      for (int k = 0; k < 300 && m_hpos != 100; k++)
         apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, IDLE);
      check_output("reach_hpos_100", hpos, 100);
      s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s.line_mid = 1'b1;
      apply_stimulus(s, 0, IDLE);
      check_output("line_start_hpos0", hpos, 0);
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, IDLE);
      check_output("after_line_ref", owner, REF);

      // Wrap at the end of the line.
      for (int k = 0; k < 300 && m_hpos != HMAX; k++)
         apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, IDLE);
      check_output("reach_hpos_max", hpos, HMAX);
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, IDLE);
      check_output("wrap_hpos0", hpos, 0);

      // Blitter and CPU contend for 20 slots.
      cpu_wins = 0;
      for (int k = 0; k < 20; k++) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0, IDLE);
`ifdef SLOT_ARB_BLIT_NICE_EN
      check_output("nice_cpu_got_slot", cpu_wins != 0, 1);
`else
      check_output("blt_beats_cpu", cpu_wins, 0);
`endif

      // Reset three cycles into a blitter slot.
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, IDLE);
      s = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      s.line_tick = 1'b1;
      apply_stimulus(s, 0, IDLE);
      check_output("pre_reset_blt", owner, BLT);
      clk7_en = 1'b0;
      cck     = 1'b0;
      repeat (3) @(negedge clk_28);
      reset = 1'b1;
      @(posedge clk_28);
      #1;
      check_output("mid_reset_gnt", gnt, 9'b000000001);
      check_output("mid_reset_hpos", hpos, 0);
      check_output("mid_reset_strobe", slot_strobe, 0);
      @(negedge clk_28);
      @(negedge clk_28);
      reset = 1'b0;
      m_hpos = 0;
      m_nice = 0;
      last_owner = IDLE;
      for (int k = 0; k < 8; k++) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0, IDLE);

      // Random traffic against the reference model.
      for (int k = 0; k < 600; k++) apply_stimulus(rnd_stim(), 0, IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
